// File: rtl/data_mem_resp.sv
// data_mem_resp: 256 x 8 data memory with a four-phase req/ack handshake and a
// programmable number of wait cycles between request capture and acknowledge.
// Optional write protection of addresses below PROT_LIMIT: define DMEM_WPROT_EN.
module data_mem_resp #(
    parameter int unsigned WAIT       = 2,
    parameter logic [7:0]  PROT_LIMIT = 8'h10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic       we,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic       ack,
    output logic [7:0] rdata,
    output logic       busy,
    output logic       err
);

    typedef enum logic [1:0] {StIdle, StBusy, StAck} state_e;

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic       we_q, we_d;
    logic [7:0] rdata_q, rdata_d;
    logic       err_q, err_d;

    // Contents are deliberately not reset.
    logic [7:0] mem [256];

    // Transaction being committed this cycle; taken straight from the inputs when
    // WAIT=0 because the capture and the commit happen on the same edge.
    logic       commit;
    logic       c_we;
    logic [7:0] c_addr;
    logic [7:0] c_wdata;
    logic       prot;
    logic       mem_we;

    // Next-state, capture and commit logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        commit  = 1'b0;
        c_we    = we_q;
        c_addr  = addr_q;
        c_wdata = wdata_q;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    addr_d  = addr;
                    wdata_d = wdata;
                    we_d    = we;
                    cnt_d   = WAIT[3:0];
                    c_we    = we;
                    c_addr  = addr;
                    c_wdata = wdata;
                    if (WAIT == 0) begin
                        state_d = StAck;
                        commit  = 1'b1;
                    end else begin
                        state_d = StBusy;
                    end
                end
            end
            StBusy: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = StAck;
                    commit  = 1'b1;
                end
            end
            StAck: begin
                if (!req) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Protection decision for the committing transaction.
    always_comb begin
`ifdef DMEM_WPROT_EN
        prot = c_we && (c_addr < PROT_LIMIT);
`else
        prot = 1'b0;
`endif
    end

    // Response data and error flag, registered on the commit edge.
    always_comb begin
        rdata_d = rdata_q;
        err_d   = err_q;
        if (commit) begin
            rdata_d = c_we ? c_wdata : mem[c_addr];
            err_d   = prot;
        end else if (state_q == StAck && !req) begin
            err_d = 1'b0;
        end
        // A clock edge while reset is held must not write the array.
        mem_we = commit && c_we && !prot && !rst;
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            addr_q  <= 8'h00;
            wdata_q <= 8'h00;
            we_q    <= 1'b0;
            rdata_q <= 8'h00;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Memory write port.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[c_addr] <= c_wdata;
        end
    end

    assign ack   = (state_q == StAck);
    assign busy  = (state_q != StIdle);
    assign rdata = rdata_q;
    assign err   = err_q;

endmodule

// File: tb/tb_data_mem_resp.sv
// Directed bench for data_mem_resp: one instance with WAIT=2, one with WAIT=0.
module tb_data_mem_resp;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, we0, ack0, busy0, err0;
    logic [7:0] addr0, wdata0, rdata0;
    logic       req1, we1, ack1, busy1, err1;
    logic [7:0] addr1, wdata1, rdata1;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    data_mem_resp #(.WAIT(2)) dut0 (
        .clk   (clk),
        .rst   (rst),
        .req   (req0),
        .we    (we0),
        .addr  (addr0),
        .wdata (wdata0),
        .ack   (ack0),
        .rdata (rdata0),
        .busy  (busy0),
        .err   (err0)
    );

    data_mem_resp #(.WAIT(0)) dut1 (
        .clk   (clk),
        .rst   (rst),
        .req   (req1),
        .we    (we1),
        .addr  (addr1),
        .wdata (wdata1),
        .ack   (ack1),
        .rdata (rdata1),
        .busy  (busy1),
        .err   (err1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Counts edges (including the sampling edge) until ack is seen, bounded.
    task automatic wait_ack(input bit sel, output int lat);
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if ((sel ? ack1 : ack0) === 1'b1) break;
        end
    endtask

    task automatic drive(input bit sel, input logic r, input logic w, input logic [7:0] a,
                         input logic [7:0] d);
        if (sel) begin
            req1 = r; we1 = w; addr1 = a; wdata1 = d;
        end else begin
            req0 = r; we0 = w; addr0 = a; wdata0 = d;
        end
    endtask

    // Full four-phase transaction with latency, data and release checks.
    task automatic txn(input bit sel, input logic w, input logic [7:0] a, input logic [7:0] d,
                       input bit chk_rd, input logic [7:0] exp_rd, input logic exp_err,
                       input string tag, output logic [7:0] rd);
        int lat;
        @(negedge clk);
        drive(sel, 1'b1, w, a, d);
        wait_ack(sel, lat);
        check({tag, "_lat"}, lat, sel ? 1 : 3);
        rd = sel ? rdata1 : rdata0;
        if (chk_rd) check({tag, "_rdata"}, rd, exp_rd);
        check({tag, "_err"}, sel ? err1 : err0, exp_err);
        @(negedge clk);
        drive(sel, 1'b0, w, a, d);
        @(posedge clk);
        #1;
        check({tag, "_ackfall"}, {sel ? ack1 : ack0, sel ? busy1 : busy0}, 2'b00);
    endtask

    logic [7:0] rd;
    logic [7:0] old02;
    int         lat;
    int         ack_cnt;
    int         busy_seen;

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        #2;
        check("rst_ack0", ack0, 1'b0);
        check("rst_busy0", busy0, 1'b0);
        check("rst_rdata0", rdata0, 8'h00);
        check("rst_err0", err0, 1'b0);
        check("rst_out1", {ack1, busy1, err1, rdata1}, 11'h000);
        @(negedge clk);
        rst = 1'b0;

        // Write then read back, WAIT=2.
        txn(1'b0, 1'b1, 8'h20, 8'h1C, 1'b1, 8'h1C, 1'b0, "wr20", rd);
        txn(1'b0, 1'b0, 8'h20, 8'h00, 1'b1, 8'h1C, 1'b0, "rd20", rd);

        // WAIT=0: preload then read.
        txn(1'b1, 1'b1, 8'h55, 8'h07, 1'b1, 8'h07, 1'b0, "w0_wr55", rd);
        txn(1'b1, 1'b0, 8'h55, 8'h00, 1'b1, 8'h07, 1'b0, "w0_rd55", rd);

        // Handshake hold: req held 5 cycles past ack.
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 8'h20, 8'h00);
        wait_ack(1'b0, lat);
        check("hold_lat", lat, 3);
        ack_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (ack0 === 1'b1) ack_cnt++;
        end
        check("hold_ack_cycles", ack_cnt, 5);
        @(negedge clk);
        req0 = 1'b0;
        @(posedge clk);
        #1;
        check("hold_ackfall", ack0, 1'b0);
        busy_seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (busy0 !== 1'b0) busy_seen++;
        end
        check("hold_no_second", busy_seen, 0);

        // Reset during BUSY aborts the write.
        txn(1'b0, 1'b1, 8'h30, 8'h11, 1'b1, 8'h11, 1'b0, "wr30", rd);
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 8'h30, 8'h55);
        @(posedge clk);
        #1;
        check("mid_busy", busy0, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_outs", {ack0, busy0, rdata0}, 10'h000);
        req0 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        txn(1'b0, 1'b0, 8'h30, 8'h00, 1'b1, 8'h11, 1'b0, "rd30_after_rst", rd);

        // Reset during ACK drops ack; the committed write stays.
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 8'h31, 8'h66);
        wait_ack(1'b0, lat);
        check("ackrst_lat", lat, 3);
        #2;
        rst = 1'b1;
        #1;
        check("ackrst_ack", ack0, 1'b0);
        req0 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        txn(1'b0, 1'b0, 8'h31, 8'h00, 1'b1, 8'h66, 1'b0, "rd31_after_rst", rd);

        // Protected region write.
`ifdef DMEM_WPROT_EN
        txn(1'b0, 1'b0, 8'h02, 8'h00, 1'b0, 8'h00, 1'b0, "pre_rd02", old02);
        txn(1'b0, 1'b1, 8'h02, 8'hFF, 1'b1, 8'hFF, 1'b1, "prot_wr02", rd);
        txn(1'b0, 1'b0, 8'h02, 8'h00, 1'b1, old02, 1'b0, "prot_rd02", rd);
`else
        old02 = 8'h00;
        txn(1'b0, 1'b1, 8'h02, 8'hFF, 1'b1, 8'hFF, 1'b0, "prot_wr02", rd);
        txn(1'b0, 1'b0, 8'h02, 8'h00, 1'b1, 8'hFF, 1'b0, "prot_rd02", rd);
`endif

        // Inputs changed during BUSY are ignored.
        txn(1'b0, 1'b1, 8'h41, 8'h00, 1'b1, 8'h00, 1'b0, "wr41", rd);
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 8'h40, 8'hA5);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 8'h41, 8'h5A);
        wait_ack(1'b0, lat);
        check("stab_lat", lat, 2);
        check("stab_rdata", rdata0, 8'hA5);
        @(negedge clk);
        req0 = 1'b0;
        @(posedge clk);
        #1;
        check("stab_ackfall", ack0, 1'b0);
        txn(1'b0, 1'b0, 8'h40, 8'h00, 1'b1, 8'hA5, 1'b0, "rd40", rd);
        txn(1'b0, 1'b0, 8'h41, 8'h00, 1'b1, 8'h00, 1'b0, "rd41", rd);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/data_mem_resp.md
DATA_MEM_RESP -- requirements
Module: data_mem_resp

Interface
REQ-001 Parameter: WAIT, default 2, number of wait cycles inserted between request capture and acknowledge (legal 0..15).
REQ-002 Parameter: PROT_LIMIT, default 8'h10, addresses below this value are write-protected when DMEM_WPROT_EN is defined.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-high.
REQ-005 Port: req  input  1  transaction request from the address-select side; held high until ack seen.
REQ-006 Port: we  input  1  1 = write, 0 = read; sampled with req.
REQ-007 Port: addr  input  8  byte address (output of the register/initial-value address mux).
REQ-008 Port: wdata  input  8  write data; sampled with req.
REQ-009 Port: ack  output  1  transaction complete; rdata valid while high.
REQ-010 Port: rdata  output  8  read data, or echoed write data for writes.
REQ-011 Port: busy  output  1  high in any state other than IDLE.
REQ-012 Port: err  output  1  write rejected by protection; valid with ack (only when DMEM_WPROT_EN is defined).

Function
REQ-013 Storage SHALL be a 256 x 8 array, with no reset of its contents.
REQ-014 The FSM SHALL have the states IDLE, BUSY and ACK.
REQ-015 IDLE: when req=1, the block SHALL latch addr/we/wdata, load a counter with WAIT, and go to BUSY (WAIT>0) or to ACK (WAIT=0).
REQ-016 BUSY: the counter SHALL decrement each cycle; when it reaches 1, the next state SHALL be ACK; req/addr/we/wdata changes in BUSY SHALL be ignored.
REQ-017 On the BUSY->ACK or IDLE->ACK transition, a write SHALL commit the latched wdata to the latched addr, and a read SHALL register mem[latched addr] into rdata.
REQ-018 For a write, rdata SHALL equal the latched wdata.
REQ-019 ACK: ack=1 SHALL be held while req=1 (four-phase handshake); when req=0, the FSM SHALL go to IDLE and ack SHALL fall on that edge.
REQ-020 Latency: ack SHALL rise WAIT+1 cycles after the edge that samples req=1 in IDLE.
REQ-021 A req still high on the cycle after ack falls SHALL NOT occur, because IDLE is entered only after req=0; the next request is accepted on the first IDLE edge with req=1.
REQ-022 rdata SHALL hold its last value outside ACK; it is only guaranteed while ack=1.
REQ-023 Address wrap-around is not applicable: the full 8-bit address space maps one-to-one onto the array, and no out-of-range condition exists.
REQ-024 busy SHALL be ~IDLE, registered with the state.

Reset
REQ-025 On rst=1, the block SHALL go immediately, without waiting for clk, to IDLE with ack=0, busy=0, err=0, rdata=8'h00 and counter=0.
REQ-026 A reset asserted in BUSY SHALL abort the transaction: no write commits, and ack never rises for it.
REQ-027 A reset asserted in ACK SHALL drop ack at once; an already committed write SHALL remain in memory.
REQ-028 After rst falls, the first rising edge with req=1 SHALL start a new transaction.

Configuration
REQ-029 Macro DMEM_WPROT_EN SHALL control write protection.
REQ-030 With DMEM_WPROT_EN defined, a write whose latched addr < PROT_LIMIT SHALL NOT modify memory, and err=1 SHALL be asserted alongside ack for the whole ACK phase.
REQ-031 With DMEM_WPROT_EN defined, err SHALL be 0 for reads and for permitted writes.
REQ-032 With DMEM_WPROT_EN defined, timing SHALL be identical for protected and unprotected writes.
REQ-033 Without DMEM_WPROT_EN, all writes SHALL commit, err SHALL be tied to 0, and PROT_LIMIT SHALL be unused.

Verification
REQ-034 Write/read, WAIT=2: write addr=8'h20, wdata=8'h1C, then read 8'h20 -> each ack rises 3 cycles after req sampled; read rdata=8'h1C.
REQ-035 WAIT=0: read of a location preloaded with 8'h07 -> ack one cycle after req sampled, rdata=8'h07.
REQ-036 Handshake hold: req kept high 5 cycles after ack -> ack stays high 5 cycles, and no second transaction occurs; ack falls on the edge after req=0.
REQ-037 Reset mid-op: write 8'h30 <= 8'h55 with reset pulsed in BUSY, then read 8'h30 -> old value returned; ack/busy go low asynchronously at reset.
REQ-038 Protected write, DMEM_WPROT_EN defined: write addr=8'h02 <= 8'hFF -> ack with err=1; a following read of 8'h02 returns the old value with err=0. Without the macro, the same write -> err=0 and the read returns 8'hFF.
REQ-039 Input stability: change addr/wdata during BUSY -> the originally latched values are used.
